// File: rtl/tcdm_arb_subsys.sv
// rtl/tcdm_arb_subsys.sv - banked TCDM, per-bank round-robin narrow ports, wide DMA port with bounded priority
// Optional response register stage: define TCDM_SUBSYS_RSP_REG_EN.
module tcdm_arb_subsys #(
  parameter int unsigned NarrowDataWidth = 64,
  parameter int unsigned TCDMDepth       = 64,
  parameter int unsigned NrBanks         = 8,
  parameter int unsigned NumInp          = 2,
  parameter int unsigned DmaStarveLimit  = 4,
  localparam int unsigned WideDataWidth  = NrBanks * NarrowDataWidth,
  localparam int unsigned TCDMAddrWidth  = $clog2(NrBanks * TCDMDepth * NarrowDataWidth / 8)
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [NumInp-1:0]                           tcdm_req_write_i,
  input  logic [NumInp-1:0][TCDMAddrWidth-1:0]        tcdm_req_addr_i,
  input  logic [NumInp-1:0][3:0]                      tcdm_req_amo_i,
  input  logic [NumInp-1:0][NarrowDataWidth-1:0]      tcdm_req_data_i,
  input  logic [NumInp-1:0][4:0]                      tcdm_req_user_core_id_i,
  input  logic [NumInp-1:0]                           tcdm_req_user_is_core_i,
  input  logic [NumInp-1:0][NarrowDataWidth/8-1:0]    tcdm_req_strb_i,
  input  logic [NumInp-1:0]                           tcdm_req_q_valid_i,
  output logic [NumInp-1:0]                           tcdm_rsp_q_ready_o,
  output logic [NumInp-1:0]                           tcdm_rsp_p_valid_o,
  output logic [NumInp-1:0][NarrowDataWidth-1:0]      tcdm_rsp_data_o,
  input  logic                                        tcdm_dma_req_write_i,
  input  logic [TCDMAddrWidth-1:0]                    tcdm_dma_req_addr_i,
  input  logic [WideDataWidth-1:0]                    tcdm_dma_req_data_i,
  input  logic [WideDataWidth/8-1:0]                  tcdm_dma_req_strb_i,
  input  logic                                        tcdm_dma_req_q_valid_i,
  output logic                                        tcdm_dma_rsp_q_ready_o,
  output logic                                        tcdm_dma_rsp_p_valid_o,
  output logic [WideDataWidth-1:0]                    tcdm_dma_rsp_data_o
);
  localparam int unsigned StrbW = NarrowDataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned BankW = $clog2(NrBanks);
  localparam int unsigned RowW  = $clog2(TCDMDepth);
  localparam int unsigned PtrW  = (NumInp > 1) ? $clog2(NumInp) : 1;

  logic [NumInp-1:0][BankW-1:0]           req_bank;
  logic [NumInp-1:0][RowW-1:0]            req_row;
  logic [RowW-1:0]                        dma_row;
  logic [3:0]                             starve_cnt;
  logic                                   hold, dma_gnt, narrow_pending;
  logic [NrBanks-1:0][PtrW-1:0]           rr_ptr, win_idx;
  logic [NrBanks-1:0]                     win_vld, bank_en, bank_we;
  logic [NumInp-1:0]                      narrow_gnt;
  logic [NrBanks-1:0][RowW-1:0]           bank_row;
  logic [NrBanks-1:0][NarrowDataWidth-1:0] bank_wdata, bank_rdata;
  logic [NrBanks-1:0][StrbW-1:0]          bank_strb;
  logic [NarrowDataWidth-1:0]             mem [NrBanks][TCDMDepth];
  logic [NumInp-1:0]                      nar_vld, nar_wr;
  logic [NumInp-1:0][BankW-1:0]           nar_bank;
  logic                                   dma_vld, dma_wr;
  logic [NumInp-1:0]                      rsp_vld_d;
  logic [NumInp-1:0][NarrowDataWidth-1:0] rsp_data_d;
  logic [WideDataWidth-1:0]               dma_data_d;
  logic                                   unused_ok;

  // AMO and user fields travel with the request but do not affect the access.
  assign unused_ok = ^{tcdm_req_amo_i, tcdm_req_user_core_id_i, tcdm_req_user_is_core_i,
                       tcdm_req_addr_i, tcdm_dma_req_addr_i};

  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      req_bank[i] = tcdm_req_addr_i[i][OffW +: BankW];
      req_row[i]  = tcdm_req_addr_i[i][OffW + BankW +: RowW];
    end
  end

  assign dma_row                = tcdm_dma_req_addr_i[OffW + BankW +: RowW];
  assign narrow_pending         = |tcdm_req_q_valid_i;
  assign hold                   = (starve_cnt == 4'(DmaStarveLimit));
  assign dma_gnt                = tcdm_dma_req_q_valid_i && !hold;
  assign tcdm_dma_rsp_q_ready_o = dma_gnt;
  assign tcdm_rsp_q_ready_o     = narrow_gnt;

  // Search order per bank starts at the rotating pointer.
  always_comb begin
    win_vld    = '0;
    win_idx    = '0;
    narrow_gnt = '0;
    for (int b = 0; b < NrBanks; b++) begin
      for (int k = 0; k < NumInp; k++) begin
        for (int i = 0; i < NumInp; i++) begin
          if (((int'(rr_ptr[b]) + k) % NumInp == i) && !dma_gnt && !win_vld[b] &&
              tcdm_req_q_valid_i[i] && (req_bank[i] == BankW'(b))) begin
            win_vld[b]    = 1'b1;
            win_idx[b]    = PtrW'(i);
            narrow_gnt[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bank_en    = '0;
    bank_we    = '0;
    bank_row   = '0;
    bank_wdata = '0;
    bank_strb  = '0;
    for (int b = 0; b < NrBanks; b++) begin
      if (dma_gnt) begin
        bank_en[b]    = 1'b1;
        bank_we[b]    = tcdm_dma_req_write_i;
        bank_row[b]   = dma_row;
        bank_wdata[b] = tcdm_dma_req_data_i[b*NarrowDataWidth +: NarrowDataWidth];
        bank_strb[b]  = tcdm_dma_req_strb_i[b*StrbW +: StrbW];
      end else begin
        for (int i = 0; i < NumInp; i++) begin
          if (narrow_gnt[i] && (req_bank[i] == BankW'(b))) begin
            bank_en[b]    = 1'b1;
            bank_we[b]    = tcdm_req_write_i[i];
            bank_row[b]   = req_row[i];
            bank_wdata[b] = tcdm_req_data_i[i];
            bank_strb[b]  = tcdm_req_strb_i[i];
          end
        end
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NrBanks; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) begin
          for (int y = 0; y < StrbW; y++) begin
            if (bank_strb[b][y]) mem[b][bank_row[b]][y*8 +: 8] <= bank_wdata[b][y*8 +: 8];
          end
        end else begin
          bank_rdata[b] <= mem[b][bank_row[b]];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
      nar_vld    <= '0;
      nar_wr     <= '0;
      nar_bank   <= '0;
      dma_vld    <= 1'b0;
      dma_wr     <= 1'b0;
    end else begin
      for (int b = 0; b < NrBanks; b++) begin
        if (win_vld[b]) rr_ptr[b] <= PtrW'((int'(win_idx[b]) + 1) % NumInp);
      end
      starve_cnt <= (dma_gnt && narrow_pending) ? starve_cnt + 4'd1 : 4'd0;
      nar_vld    <= narrow_gnt;
      nar_wr     <= tcdm_req_write_i;
      nar_bank   <= req_bank;
      dma_vld    <= dma_gnt;
      dma_wr     <= tcdm_dma_req_write_i;
    end
  end

  always_comb begin
    for (int i = 0; i < NumInp; i++) begin
      rsp_vld_d[i]  = nar_vld[i];
      rsp_data_d[i] = (nar_vld[i] && !nar_wr[i]) ? bank_rdata[nar_bank[i]] : '0;
    end
    dma_data_d = (dma_vld && !dma_wr) ? bank_rdata : '0;
  end

`ifdef TCDM_SUBSYS_RSP_REG_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcdm_rsp_p_valid_o     <= '0;
      tcdm_rsp_data_o        <= '0;
      tcdm_dma_rsp_p_valid_o <= 1'b0;
      tcdm_dma_rsp_data_o    <= '0;
    end else begin
      tcdm_rsp_p_valid_o     <= rsp_vld_d;
      tcdm_rsp_data_o        <= rsp_data_d;
      tcdm_dma_rsp_p_valid_o <= dma_vld;
      tcdm_dma_rsp_data_o    <= dma_data_d;
    end
  end
`else
  assign tcdm_rsp_p_valid_o     = rsp_vld_d;
  assign tcdm_rsp_data_o        = rsp_data_d;
  assign tcdm_dma_rsp_p_valid_o = dma_vld;
  assign tcdm_dma_rsp_data_o    = dma_data_d;
`endif

endmodule
